// File: rtl/sm_display.sv
// Four-digit multiplexed seven-segment display for a signed 16-bit value.
// A sequential double-dabble converts the magnitude, and the scan runs independently of that conversion.
module sm_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] mag,
    input  logic        sign,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        overflow
);

    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    state_t        state_q, state_d;
    logic [15:0]   shift_q, shift_d;
    logic [19:0]   bcd_q, bcd_d;
    logic [19:0]   adj;
    logic [4:0]    bitCnt_q, bitCnt_d;
    logic          sign_q, sign_d;
    logic [15:0]   dispBcd_q, dispBcd_d;
    logic          dispNeg_q, dispNeg_d;
    logic          ovf_q, ovf_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;

    function automatic logic [3:0] addThree(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        case (nib)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Leading-zero blanking: tens/hundreds only light when a higher or equal digit is nonzero.
    function automatic logic [6:0] digitSeg(input logic [1:0] idx, input logic [15:0] bcd,
                                            input logic neg, input logic ovf);
        if (ovf) return SEG_DASH;
        case (idx)
            2'd0:    return glyph(bcd[3:0]);
            2'd1:    return (bcd[15:4] == 12'd0) ? SEG_BLANK : glyph(bcd[7:4]);
            2'd2:    return (bcd[15:8] == 8'd0)  ? SEG_BLANK : glyph(bcd[11:8]);
            default: return neg ? SEG_DASH : SEG_BLANK;
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            adj[4*i +: 4] = addThree(bcd_q[4*i +: 4]);
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bcd_d     = bcd_q;
        bitCnt_d  = bitCnt_q;
        sign_d    = sign_q;
        dispBcd_d = dispBcd_q;
        dispNeg_d = dispNeg_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shift_d  = mag;
                    sign_d   = sign;
                    bcd_d    = 20'd0;
                    bitCnt_d = 5'd0;
                    state_d  = CONV;
                end
            end
            CONV: begin
                bcd_d    = {adj[18:0], shift_q[15]};
                shift_d  = {shift_q[14:0], 1'b0};
                bitCnt_d = bitCnt_q + 5'd1;
                if (bitCnt_q == 5'd15) state_d = LOAD;
            end
            LOAD: begin
                // A value above 999 always has a nonzero thousands or ten-thousands digit.
                dispBcd_d = bcd_q[15:0];
                ovf_d     = |bcd_q[19:12];
                dispNeg_d = sign_q && (|bcd_q);
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
        idx_d   = (presc_q == PRESC_MAX) ? idx_q + 2'd1 : idx_q;
        an_d    = ~(4'b0001 << idx_d);
        seg_d   = digitSeg(idx_d, dispBcd_q, dispNeg_q, ovf_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bcd_q     <= '0;
            bitCnt_q  <= '0;
            sign_q    <= 1'b0;
            dispBcd_q <= '0;
            dispNeg_q <= 1'b0;
            ovf_q     <= 1'b0;
            presc_q   <= '0;
            idx_q     <= '0;
            an_q      <= 4'b1110;
            seg_q     <= 7'b1000000;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bcd_q     <= bcd_d;
            bitCnt_q  <= bitCnt_d;
            sign_q    <= sign_d;
            dispBcd_q <= dispBcd_d;
            dispNeg_q <= dispNeg_d;
            ovf_q     <= ovf_d;
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign an       = an_q;
    assign seg      = seg_q;
    assign dp       = 1'b1;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_sm_display.sv
// Scoreboard bench for sm_display: expected digit glyphs are queued per transfer
// and compared against a full scan of the multiplexed outputs.
module tb_sm_display;

    localparam int DIV = 4;

    typedef struct packed {
        logic [27:0] segs;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] magIn = '0;
    logic        signIn = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        overflow;

    int   errCount = 0;
    int   checkCount = 0;
    logic lastOvf = 1'b0;
    exp_t sbQ[$];

    sm_display #(.REFRESH_DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mag(magIn), .sign(signIn), .an(an), .seg(seg), .dp(dp), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [6:0] glyphOf(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic exp_t modelDisplay(input int m, input bit s);
        exp_t e;
        int h, t, u;
        if (m > 999) begin
            e.ovf  = 1'b1;
            e.segs = {4{7'b0111111}};
        end else begin
            h = m / 100;
            t = (m / 10) % 10;
            u = m % 10;
            e.ovf = 1'b0;
            e.segs[6:0]   = glyphOf(u);
            e.segs[13:7]  = (h == 0 && t == 0) ? 7'b1111111 : glyphOf(t);
            e.segs[20:14] = (h == 0) ? 7'b1111111 : glyphOf(h);
            e.segs[27:21] = (s && m != 0) ? 7'b0111111 : 7'b1111111;
        end
        return e;
    endfunction

    // Drives one transfer and checks handshake timing; holdValid keeps in_valid high with junk during CONV.
    task automatic applyStimulus(input int m, input bit s, input bit holdValid);
        exp_t e;
        e = modelDisplay(m, s);
        @(negedge clk);
        checkOutput("readyIdle", in_ready, 1);
        in_valid = 1'b1;
        magIn = 16'(m);
        signIn = s;
        sbQ.push_back(e);
        @(negedge clk);
        if (holdValid) begin
            magIn = 16'(m + 111);
            signIn = ~s;
        end else begin
            in_valid = 1'b0;
        end
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (holdValid && k < 16) magIn = 16'(m + 7 * k + 3);
            if (k == 1) checkOutput("readyBusyFirst", in_ready, 0);
            if (k == 16) begin
                checkOutput("readyBusyLast", in_ready, 0);
                checkOutput("ovfBeforeLoad", overflow, lastOvf);
                in_valid = 1'b0;
            end
            if (k == 17) begin
                checkOutput("readyAfterLoad", in_ready, 1);
                checkOutput("ovfAtLoad", overflow, e.ovf);
            end
        end
        lastOvf = e.ovf;
    endtask

    task automatic scanDisplay();
        logic [6:0] capSeg [4];
        logic [3:0] seen;
        logic [3:0] prevAn;
        exp_t       e;
        seen = '0;
        for (int d = 0; d < 4; d++) capSeg[d] = 7'h7f;
        repeat (2) @(negedge clk);
        prevAn = an;
        for (int c = 0; c < 17; c++) begin
            if (c > 0) begin
                @(negedge clk);
                if (an != prevAn) checkOutput("anStep", an, {prevAn[2:0], prevAn[3]});
                prevAn = an;
            end
            case (an)
                4'b1110: begin capSeg[0] = seg; seen[0] = 1'b1; end
                4'b1101: begin capSeg[1] = seg; seen[1] = 1'b1; end
                4'b1011: begin capSeg[2] = seg; seen[2] = 1'b1; end
                4'b0111: begin capSeg[3] = seg; seen[3] = 1'b1; end
                default: checkOutput("anOneHot", an, 4'b1110);
            endcase
        end
        if (sbQ.size() == 0) begin
            checkOutput("sbEmpty", 0, 1);
        end else begin
            e = sbQ.pop_front();
            checkOutput("digitsSeen", seen, 4'hf);
            for (int d = 0; d < 4; d++) checkOutput($sformatf("seg%0d", d), capSeg[d], e.segs[7*d +: 7]);
            checkOutput("overflow", overflow, e.ovf);
            checkOutput("dp", dp, 1);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("rstReady", in_ready, 1);
        checkOutput("rstAn", an, 4'b1110);
        checkOutput("rstSeg", seg, 7'b1000000);
        checkOutput("rstOvf", overflow, 0);
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            checkOutput($sformatf("anDwell%0d", k), an, 32'(4'(~(4'b0001 << ((k / DIV) % 4)))));
        end
        sbQ.push_back(modelDisplay(0, 1'b0));
        scanDisplay();

        applyStimulus(128, 1'b1, 1'b0);  scanDisplay();
        applyStimulus(5, 1'b0, 1'b0);    scanDisplay();
        applyStimulus(0, 1'b1, 1'b0);    scanDisplay();
        applyStimulus(1000, 1'b0, 1'b0); scanDisplay();
        applyStimulus(999, 1'b0, 1'b0);  scanDisplay();
        applyStimulus(300, 1'b0, 1'b1);  scanDisplay();

        // Abort a conversion of 77 with reset at edge 8.
        @(negedge clk);
        in_valid = 1'b1;
        magIn = 16'd77;
        signIn = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abortReady", in_ready, 1);
        checkOutput("abortAn", an, 4'b1110);
        checkOutput("abortSeg", seg, 7'b1000000);
        checkOutput("abortOvf", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        lastOvf = 1'b0;
        repeat (20) @(negedge clk);
        sbQ.push_back(modelDisplay(0, 1'b0));
        scanDisplay();
        applyStimulus(42, 1'b0, 1'b0); scanDisplay();

        for (int r = 0; r < 4; r++) begin
            applyStimulus(int'($urandom_range(0, 1100)), 1'($urandom_range(0, 1)), 1'b0);
            scanDisplay();
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/sm_display.md
SM_DISPLAY -- requirements
Module: sm_display

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 100000, giving the clk cycles each digit is enabled during multiplexing (minimum 2).
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert and active-low.
REQ-004 in_valid  input  1  mag/sign present a new value to display.
REQ-005 in_ready  output  1  block can accept a value this cycle.
REQ-006 mag  input  16  unsigned magnitude from the two's-complement-to-sign-magnitude stage.
REQ-007 sign  input  1  1 = negative value.
REQ-008 an  output  4  digit enables, active-low one-hot; an[0] is the rightmost digit.
REQ-009 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 dp  output  1  decimal point, active-low; SHALL be held at 1.
REQ-011 overflow  output  1  displayed value exceeds 999.

Function
REQ-012 The block SHALL use a three-state FSM: IDLE, CONV and LOAD.
REQ-013 in_ready SHALL be 1 in IDLE only.
REQ-014 A transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; mag and sign are latched and the state goes to CONV.
REQ-015 in_valid while in_ready=0 SHALL be ignored; no value is queued.
REQ-016 CONV SHALL perform a sequential shift-add-3 (double-dabble) conversion of the latched 16-bit mag, one bit per cycle, MSB first, for exactly 16 cycles into a 20-bit BCD register.
REQ-017 LOAD SHALL last one cycle, write the display register (BCD digits, sign, overflow) and return to IDLE.
REQ-018 Latency: if the transfer is edge 0, the display register and overflow SHALL update on edge 17, and in_ready SHALL be 1 from edge 17.
REQ-019 The display register SHALL hold its value until the next LOAD.
REQ-020 overflow SHALL be 1 when the loaded mag > 999, else 0.
REQ-021 When overflow=1, all four digits SHALL show '-' (seg=0111111).
REQ-022 When overflow=0, digit 0 SHALL always show the units BCD digit.
REQ-023 When overflow=0, digits 1 and 2 SHALL be blank (seg=1111111) when that digit and all more-significant magnitude digits are zero; otherwise they show their BCD digit.
REQ-024 When overflow=0, digit 3 SHALL show '-' when sign=1 and mag!=0, and SHALL be blank otherwise; negative zero displays as "0".
REQ-025 Digit glyphs (seg, active-low) SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-026 A prescaler SHALL count 0..REFRESH_DIV-1 and wrap; on each wrap a 2-bit digit index SHALL increment 0->1->2->3->0.
REQ-027 an SHALL be the active-low one-hot of the index, and seg SHALL be the glyph for that digit; both are registered and change on the same edge.
REQ-028 Multiplexing SHALL run continuously and independently of the FSM; a LOAD mid-scan takes effect on the current digit from the next edge.

Reset
REQ-029 While rst_n=0, the block SHALL set: state IDLE, in_ready=1, prescaler=0, index=0, an=1110, display register = +0, seg=1000000, overflow=0, dp=1.
REQ-030 Reset asserted during CONV or LOAD SHALL abort the conversion with no display update; after release the block accepts a new value immediately.

Verification (REFRESH_DIV=4)
REQ-031 Reset release, no input -> an=1110, seg=1000000, and an cycles 1110,1101,1011,0111 every 4 clks; digits 1-3 blank.
REQ-032 Transfer mag=128, sign=1 -> in_ready=0 for edges 1-16, LOAD on edge 17; scan shows d3='-', d2='1', d1='2', d0='8'; overflow=0.
REQ-033 Transfer mag=5, sign=0, then mag=0, sign=1 -> first shows blank, blank, blank, '5'; second shows blank, blank, blank, '0' with no minus.
REQ-034 Transfer mag=1000, sign=0 -> overflow=1 and all digits 0111111; then mag=999 -> overflow=0 and blank, '9', '9', '9'.
REQ-035 in_valid held high with changing mag during CONV -> only the first value is displayed; the next value is accepted on edge 17 or later.
REQ-036 rst_n pulsed low at edge 8 of the conversion of mag=77 -> display shows +0 and 77 never appears; a new transfer of mag=42 then displays '4', '2' correctly.
